rgb2raw_bayer_mosaic: RTL and testbench

- Re-mosaics a full-RGB pixel stream into a single-channel Bayer RAW stream.
- Inverse of the team's bilinear demosaic: for each pixel it keeps only the colour component that the configured CFA phase places at that (row, column), and discards the other two.
- Sits in front of `raw2rgb_bilinear_interp` for loop-back verification and for feeding synthetic RGB/test patterns into the RAW/HDR pipeline.
- Uses the same valid/sop/eop line-framing as the RAW path.

---
 rtl/rgb2raw_pkg.sv | 7 +
 rtl/rgb2raw_bayer_mosaic_delay_rg.sv | 17 +
 rtl/rgb2raw_bayer_mosaic.sv | 92 +++++++++
 tb/tb_rgb2raw_bayer_mosaic.sv | 132 +++++++++++++
 4 files changed

// File: rtl/rgb2raw_pkg.sv
// rgb2raw_pkg: shared types and default frame geometry for the RGB-to-Bayer re-mosaic path.
package rgb2raw_pkg;
  typedef enum logic [1:0] {RGGB, GRBG, GBRG, BGGR} bayer_phase_t;
  typedef enum logic {IDLE, IN_LINE} line_state_t;
  localparam int DEF_LINE_PIXELS = 1280;
  localparam int DEF_FRAME_LINES = 720;
endpackage

// File: rtl/rgb2raw_bayer_mosaic_delay_rg.sv
// delay_rg: W-bit shift register of depth D (D >= 1) with synchronous active-low clear.
module delay_rg #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr_q [D];
  always_ff @(posedge clk) begin
    sr_q[0] <= !reset_n ? '0 : d;
    for (int i = 1; i < D; i++) sr_q[i] <= !reset_n ? '0 : sr_q[i-1];
  end
  assign q = sr_q[D-1];
endmodule

// File: rtl/rgb2raw_bayer_mosaic.sv
// rgb2raw_bayer_mosaic: keeps the CFA-selected colour of each RGB pixel to form a Bayer RAW stream.
// Define RGB2RAW_PIPELINE_EN to register inputs before colour select (latency 2 instead of 1).
module rgb2raw_bayer_mosaic
  import rgb2raw_pkg::*;
#(
  parameter int         DATA_WIDTH  = 8,
  parameter int         LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int         FRAME_LINES = DEF_FRAME_LINES,
  parameter logic [1:0] BAYER_PHASE = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [DATA_WIDTH-1:0] g_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  data_i_valid,
  input  logic                  sop_i,
  input  logic                  eop_i,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  output logic                  raw_sop,
  output logic                  raw_eop,
  output logic                  line_err,
  output logic                  frame_done
);
  localparam int CW = $clog2(LINE_PIXELS) + 1;
  localparam int RW = FRAME_LINES > 1 ? $clog2(FRAME_LINES) : 1;
  logic s_valid, s_sop, s_eop;
  logic [DATA_WIDTH-1:0] s_r, s_g, s_b;
`ifdef RGB2RAW_PIPELINE_EN
  logic [3*DATA_WIDTH-1:0] rgb_q, rgb_d;
  assign rgb_d = {r_data, g_data, b_data};
  always_ff @(posedge clk) rgb_q <= !reset_n ? '0 : rgb_d;
  assign {s_r, s_g, s_b} = rgb_q;
  delay_rg #(.W(3), .D(1)) u_in_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({data_i_valid, sop_i, eop_i}),
    .q       ({s_valid, s_sop, s_eop})
  );
`else
  assign {s_valid, s_sop, s_eop} = {data_i_valid, sop_i, eop_i};
  assign {s_r, s_g, s_b} = {r_data, g_data, b_data};
`endif
  line_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0] raw_data_q, raw_data_d;
  logic line_err_q, line_err_d, frame_done_q, frame_done_d;
  logic emit, last_row, rp, cp;
  // col_cur is the column of the pixel in this cycle; it sticks at LINE_PIXELS once overrun
  always_comb begin
    emit         = s_valid && (s_sop || state_q == IN_LINE);
    last_row     = row_q == RW'(FRAME_LINES - 1);
    col_cur      = s_sop ? '0 : (col_q == CW'(LINE_PIXELS) ? col_q : col_q + CW'(1));
    col_d        = emit ? col_cur : col_q;
    row_d        = (emit && s_eop) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    state_d      = emit ? (s_eop ? IDLE : IN_LINE) : state_q;
    rp           = row_q[0] ^ BAYER_PHASE[1];
    cp           = col_cur[0] ^ BAYER_PHASE[0];
    raw_data_d   = !emit ? raw_data_q : (rp != cp) ? s_g : (rp ? s_b : s_r);
    line_err_d   = s_valid && (!emit || (s_sop && state_q == IN_LINE) ||
                   (s_eop && col_cur != CW'(LINE_PIXELS - 1)));
    frame_done_d = emit && s_eop && last_row;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      raw_data_q   <= '0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      raw_data_q   <= raw_data_d;
      line_err_q   <= line_err_d;
      frame_done_q <= frame_done_d;
    end
  end
  delay_rg #(.W(3), .D(1)) u_out_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({emit, emit && s_sop, emit && s_eop}),
    .q       ({raw_valid, raw_sop, raw_eop})
  );
  assign raw_data   = raw_data_q;
  assign line_err   = line_err_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_rgb2raw_bayer_mosaic.sv
// tb_rgb2raw_bayer_mosaic: scoreboard bench running RGGB and BGGR instances on one stimulus stream.
module tb_rgb2raw_bayer_mosaic;
`ifdef RGB2RAW_PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] r_data = '0, g_data = '0, b_data = '0;
  logic data_i_valid = 1'b0, sop_i = 1'b0, eop_i = 1'b0;
  logic [7:0] raw_data, raw_data_b;
  logic raw_valid, raw_sop, raw_eop, line_err, frame_done;
  logic raw_valid_b, raw_sop_b, raw_eop_b, line_err_b, frame_done_b;
  typedef struct {
    logic       v, s, e, err, fd;
    logic [7:0] d0, d3;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int errors = 0, checks = 0, k = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  rgb2raw_bayer_mosaic #(.DATA_WIDTH(8), .LINE_PIXELS(4), .FRAME_LINES(2), .BAYER_PHASE(2'd0)) dut_a (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .data_i_valid(data_i_valid), .sop_i(sop_i), .eop_i(eop_i),
    .raw_data(raw_data), .raw_valid(raw_valid), .raw_sop(raw_sop), .raw_eop(raw_eop),
    .line_err(line_err), .frame_done(frame_done)
  );
  rgb2raw_bayer_mosaic #(.DATA_WIDTH(8), .LINE_PIXELS(4), .FRAME_LINES(2), .BAYER_PHASE(2'd3)) dut_b (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .data_i_valid(data_i_valid), .sop_i(sop_i), .eop_i(eop_i),
    .raw_data(raw_data_b), .raw_valid(raw_valid_b), .raw_sop(raw_sop_b), .raw_eop(raw_eop_b),
    .line_err(line_err_b), .frame_done(frame_done_b)
  );
  function automatic logic [7:0] pick(input int ph, input int row, input int col,
                                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int rp, cp;
    rp = (row & 1) ^ ((ph >> 1) & 1);
    cp = (col & 1) ^ (ph & 1);
    return (rp == 0 && cp == 0) ? r : (rp == 1 && cp == 1) ? b : g;
  endfunction
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en && sb.size() >= LAT) begin
      cur = sb.pop_front();
      chk("valid", {7'd0, raw_valid}, {7'd0, cur.v});
      chk("sop", {7'd0, raw_sop}, {7'd0, cur.s});
      chk("eop", {7'd0, raw_eop}, {7'd0, cur.e});
      chk("line_err", {7'd0, line_err}, {7'd0, cur.err});
      chk("frame_done", {7'd0, frame_done}, {7'd0, cur.fd});
      chk("bggr_valid", {7'd0, raw_valid_b}, {7'd0, cur.v});
      chk("bggr_line_err", {7'd0, line_err_b}, {7'd0, cur.err});
      if (cur.v) begin
        chk("rggb_data", raw_data, cur.d0);
        chk("bggr_data", raw_data_b, cur.d3);
      end
    end
  end
  // Drives one cycle and records what both instances must emit LAT cycles later.
  task automatic drive(input logic v, input logic s, input logic e, input logic ov,
                       input int row, input int col, input logic err, input logic fd);
    exp_t x;
    @(negedge clk);
    #1;
    k++;
    r_data = 8'(k); g_data = 8'(k + 64); b_data = 8'(k + 128);
    data_i_valid = v; sop_i = s; eop_i = e;
    x.v = ov; x.s = ov & s; x.e = ov & e; x.err = err; x.fd = fd;
    x.d0 = pick(0, row, col, r_data, g_data, b_data);
    x.d3 = pick(3, row, col, r_data, g_data, b_data);
    sb.push_back(x);
  endtask
  task automatic px(input logic s, input logic e, input int row, input int col,
                    input logic err = 1'b0, input logic fd = 1'b0);
    drive(1'b1, s, e, 1'b1, row, col, err, fd);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic line(input int row, input logic fd);
    for (int c = 0; c < 4; c++) px(c == 0, c == 3, row, c, 1'b0, fd && c == 3);
  endtask
  task automatic do_reset(input logic with_pixel);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    sb.delete();
    reset_n = 1'b0;
    data_i_valid = with_pixel; sop_i = 1'b0; eop_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_data", raw_data, 8'h00);
    chk("rst_valid", {7'd0, raw_valid}, 8'h00);
    chk("rst_sop", {7'd0, raw_sop}, 8'h00);
    chk("rst_eop", {7'd0, raw_eop}, 8'h00);
    chk("rst_line_err", {7'd0, line_err}, 8'h00);
    chk("rst_frame_done", {7'd0, frame_done}, 8'h00);
    chk("rst_bggr_data", raw_data_b, 8'h00);
    reset_n = 1'b1;
    data_i_valid = 1'b0;
    chk_en = 1'b1;
  endtask
  initial begin
    do_reset(1'b0);
    line(0, 1'b0);
    line(1, 1'b1);
    px(1, 0, 0, 0); idle(1); px(0, 0, 0, 1); idle(3); px(0, 0, 0, 2); idle(2); px(0, 1, 0, 3);
    px(1, 0, 1, 0); px(0, 0, 1, 1); px(0, 1, 1, 2, 1'b1, 1'b1);
    px(1, 0, 0, 0); px(0, 0, 0, 1); px(0, 0, 0, 2);
    px(1, 0, 0, 0, 1'b1); px(0, 0, 0, 1); px(0, 0, 0, 2); px(0, 1, 0, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(1);
    px(1, 0, 1, 0); px(0, 0, 1, 1); px(0, 0, 1, 2); px(0, 0, 1, 3);
    px(0, 0, 1, 4); px(0, 0, 1, 4); px(0, 1, 1, 4, 1'b1, 1'b1);
    px(1, 1, 0, 0, 1'b1);
    line(1, 1'b1);
    line(0, 1'b0);
    px(1, 0, 1, 0); px(0, 0, 1, 1);
    do_reset(1'b1);
    line(0, 1'b0);
    idle(LAT + 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
